// File: rtl/dot4x_reset_phase_gen.sv
// dot4x_reset_phase_gen: qualifies MMCM lock, releases a phi-aligned core reset and decodes dot/phi strobes; LOCK_LOSS_COUNT_EN builds the lock-loss counter
module dot4x_reset_phase_gen #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int SYNC_STAGES        = 2
) (
  input  logic       clk_dot4x,
  input  logic       reset_n,
  input  logic       locked,
  output logic       sys_rst,
  output logic       dot_en,
  output logic       phi,
  output logic       phi_rise,
  output logic       phi_fall,
  output logic [4:0] phase,
  output logic [7:0] lock_loss_count
);
  localparam int CW = $clog2(LOCK_STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_state, w_state_nx;
  logic [CW-1:0]          r_cnt, w_cnt_nx;
  logic [4:0]             w_phase_nx;
  logic                   w_locked_s, w_run_nx;
  assign w_locked_s = r_sync[SYNC_STAGES-1];
  assign w_run_nx   = w_state_nx == S_RUN;
  // bring the asynchronous lock flag into the dot4x domain
  always_ff @(posedge clk_dot4x)
    r_sync <= !reset_n ? '0 : {r_sync[SYNC_STAGES-2:0], locked};
  // lock qualification sequence; losing lock at any point restarts from scratch
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_phase_nx = phase;
    if (!w_locked_s) begin
      w_state_nx = S_WAIT;
      w_cnt_nx   = '0;
      w_phase_nx = '0;
    end else begin
      case (r_state)
        S_WAIT:  w_state_nx = S_COUNT;
        S_COUNT: begin
          w_state_nx = (r_cnt == CNT_MAX) ? S_HOLD : S_COUNT;
          w_cnt_nx   = (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
        end
        S_HOLD: begin
          w_state_nx = (phase == 5'd31) ? S_RUN : S_HOLD;
          w_phase_nx = phase + 5'd1;
        end
        S_RUN:   w_phase_nx = phase + 5'd1;
      endcase
    end
  end
  // outputs decode the upcoming phase so each strobe lines up with the phase it is shown with
  always_ff @(posedge clk_dot4x) begin
    if (!reset_n) begin
      r_state  <= S_WAIT;
      r_cnt    <= '0;
      phase    <= '0;
      sys_rst  <= 1'b1;
      dot_en   <= 1'b0;
      phi      <= 1'b0;
      phi_rise <= 1'b0;
      phi_fall <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      phase    <= w_phase_nx;
      sys_rst  <= !w_run_nx;
      dot_en   <= w_run_nx && (w_phase_nx[1:0] == 2'd3);
      phi      <= w_run_nx && w_phase_nx[4];
      phi_rise <= w_run_nx && (w_phase_nx == 5'd16);
      phi_fall <= w_run_nx && (w_phase_nx == 5'd0);
    end
  end
`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0] r_llc;
  // count only losses that tear down a running core, saturating
  always_ff @(posedge clk_dot4x) begin
    if (!reset_n)
      r_llc <= '0;
    else if (r_state == S_RUN && !w_locked_s && r_llc != 8'hff)
      r_llc <= r_llc + 8'd1;
  end
  assign lock_loss_count = r_llc;
`else
  assign lock_loss_count = 8'd0;
`endif
endmodule

// File: tb/tb_dot4x_reset_phase_gen.sv
// tb_dot4x_reset_phase_gen: scoreboard bench against a lock-streak reference model; LOCK_LOSS_COUNT_EN selects counter expectations
module tb_dot4x_reset_phase_gen;
  localparam int LSC  = 16;
  localparam int SYNC = 2;
  localparam int RUN_TH = LSC + 33;
  typedef struct packed {
    logic       sys_rst;
    logic       dot_en;
    logic       phi;
    logic       rise;
    logic       fall;
    logic [4:0] phase;
    logic [7:0] llc;
  } exp_t;
  logic clk = 0;
  logic reset_n = 0;
  logic locked = 1;
  logic sys_rst, dot_en, phi, phi_rise, phi_fall;
  logic [4:0] phase;
  logic [7:0] lock_loss_count;
  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  bit   hist[SYNC];
  int   streak = 0;
  int   m_llc = 0;
  bit   m_rst = 1;
  int   m_phase = 0;
  dot4x_reset_phase_gen #(.LOCK_STABLE_CYCLES(LSC), .SYNC_STAGES(SYNC)) dut (
    .clk_dot4x(clk), .reset_n(reset_n), .locked(locked), .sys_rst(sys_rst),
    .dot_en(dot_en), .phi(phi), .phi_rise(phi_rise), .phi_fall(phi_fall),
    .phase(phase), .lock_loss_count(lock_loss_count)
  );
  always #5 clk = ~clk;
  // reference: the core runs once the synchronized lock has been high for 1+LSC+32 edges; phase counts from the end of qualification
  always @(posedge clk) begin
    bit ls;
    exp_t e;
    ls = hist[0];
    if (!reset_n) begin
      for (int i = 0; i < SYNC; i++) hist[i] = 0;
      streak = 0;
      m_llc = 0;
    end else begin
      for (int i = 0; i < SYNC - 1; i++) hist[i] = hist[i+1];
      hist[SYNC-1] = locked;
`ifdef LOCK_LOSS_COUNT_EN
      if (!ls && streak >= RUN_TH && m_llc < 255) m_llc++;
`endif
      streak = ls ? (streak < 1000000 ? streak + 1 : streak) : 0;
    end
    m_rst   = streak < RUN_TH;
    m_phase = streak >= LSC + 1 ? (streak - LSC - 1) % 32 : 0;
    e.sys_rst = m_rst;
    e.dot_en  = !m_rst && (m_phase % 4 == 3);
    e.phi     = !m_rst && (m_phase >= 16);
    e.rise    = !m_rst && (m_phase == 16);
    e.fall    = !m_rst && (m_phase == 0);
    e.phase   = 5'(m_phase);
    e.llc     = 8'(m_llc);
    sb.push_back(e);
  end
  // monitor: every edge presents a new output set
  always @(posedge clk) begin
    exp_t e, g;
    #1;
    g = {sys_rst, dot_en, phi, phi_rise, phi_fall, phase, lock_loss_count};
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL sb_empty got=%h", g);
    end else begin
      e = sb.pop_front();
      if (g !== e) begin
        fails++;
        $display("FAIL outputs t=%0t got rst=%b den=%b phi=%b rise=%b fall=%b ph=%0d llc=%0d exp rst=%b den=%b phi=%b rise=%b fall=%b ph=%0d llc=%0d",
          $time, g.sys_rst, g.dot_en, g.phi, g.rise, g.fall, g.phase, g.llc,
          e.sys_rst, e.dot_en, e.phi, e.rise, e.fall, e.phase, e.llc);
      end
    end
  end
  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_run_phase(input int p);
    for (int i = 0; i < 2000 && !(!m_rst && m_phase == p); i++) tick();
    chk("wait_run_phase", int'(!m_rst && m_phase == p), 1);
  endtask
  task automatic release_latency(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (sys_rst && n < 300);
    chk(name, n, SYNC + 1 + LSC + 32);
    tick();
  endtask
  initial begin
    int n;
    tick(4);
    reset_n = 1;
    release_latency("release_latency");
    chk("first_run_phase", phase, 0);
    tick(64);
    wait_run_phase(10);
    locked = 0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      locked = 1;
    end while (!sys_rst && n < 20);
    chk("assert_latency", n, SYNC + 1);
    tick();
    for (int i = 0; i < 200 && streak != 10; i++) tick();
    chk("reach_cnt9", streak, 10);
    locked = 0;
    tick();
    locked = 1;
    release_latency("glitch_release_latency");
    wait_run_phase(20);
    reset_n = 0;
    tick();
    chk("reset_midrun_rst", sys_rst, 1);
    chk("reset_midrun_phase", phase, 0);
    chk("reset_midrun_strobes", {dot_en, phi, phi_rise, phi_fall}, 0);
    chk("reset_midrun_llc", lock_loss_count, 0);
    reset_n = 1;
    for (int k = 0; k < 300; k++) begin
      wait_run_phase($urandom_range(0, 31));
      locked = 0;
      tick($urandom_range(1, 3));
      locked = 1;
    end
    for (int i = 0; i < 200 && streak != 5; i++) tick();
    locked = 0;
    tick();
    locked = 1;
    wait_run_phase(0);
`ifdef LOCK_LOSS_COUNT_EN
    chk("llc_saturated", lock_loss_count, 255);
`else
    chk("llc_disabled", lock_loss_count, 0);
`endif
    for (int i = 0; i < 6000; i++) begin
      reset_n = ($urandom % 400) != 0;
      locked  = ($urandom % 60) != 0;
      tick();
    end
    reset_n = 1;
    locked = 1;
    tick(60);
    chk("final_released", sys_rst, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
